fp_mul_div: RTL and testbench

FP_MUL_DIV -- requirements
Module: fp_mul_div

---
 rtl/fp_mul_div.sv | 176 +++++++++++++++++
 tb/tb_fp_mul_div.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fp_mul_div.sv
// Single-cycle IEEE-754 binary32 multiplier/divider with round-to-nearest-even,
// flush-to-zero on subnormal inputs and underflow, and per-operation exception flags.
module fp_mul_div (
   input  logic        clk,
   input  logic        arst,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        sel,
   input  logic        en,
   output logic [31:0] R,
   output logic        io_flag,
   output logic        dz_flag,
   output logic        of_flag,
   output logic        uf_flag,
   output logic        i_flag
);

   localparam logic [31:0] QNAN = 32'h7FC00000;

   logic [7:0]  w_aExp, w_bExp;
   logic [22:0] w_aFrac, w_bFrac;
   logic        w_aZero, w_bZero, w_aInf, w_bInf, w_aNan, w_bNan, w_aSnan, w_bSnan;
   logic        w_sign;
   logic [23:0] w_aMan, w_bMan;

   assign w_aExp  = a[30:23];
   assign w_bExp  = b[30:23];
   assign w_aFrac = a[22:0];
   assign w_bFrac = b[22:0];
   assign w_sign  = a[31] ^ b[31];

   // A zero exponent covers both true zeros and subnormals, which are flushed.
   assign w_aZero = (w_aExp == 8'd0);
   assign w_bZero = (w_bExp == 8'd0);
   assign w_aInf  = (w_aExp == 8'hFF) && (w_aFrac == 23'd0);
   assign w_bInf  = (w_bExp == 8'hFF) && (w_bFrac == 23'd0);
   assign w_aNan  = (w_aExp == 8'hFF) && (w_aFrac != 23'd0);
   assign w_bNan  = (w_bExp == 8'hFF) && (w_bFrac != 23'd0);
   assign w_aSnan = w_aNan && !w_aFrac[22];
   assign w_bSnan = w_bNan && !w_bFrac[22];

   assign w_aMan = {1'b1, w_aFrac};
   assign w_bMan = {1'b1, w_bFrac};

   logic [47:0] w_prod;
   logic [49:0] w_divNum, w_divDen;
   logic [26:0] w_quot;
   logic        w_divRemNz;

   assign w_prod     = 48'(w_aMan) * 48'(w_bMan);
   // Pre-shifting the dividend by 26 leaves 26-27 quotient bits: 24 kept, guard, round.
   assign w_divNum   = {w_aMan, 26'd0};
   assign w_divDen   = {26'd0, w_bMan};
   assign w_quot     = 27'(w_divNum / w_divDen);
   assign w_divRemNz = (w_divNum % w_divDen) != 50'd0;

   logic [23:0]        w_sig;
   logic               w_guard, w_round, w_sticky;
   logic signed [9:0]  w_exp;

   always_comb begin
      w_sig    = '0;
      w_guard  = 1'b0;
      w_round  = 1'b0;
      w_sticky = 1'b0;
      w_exp    = '0;
      if (!sel) begin
         if (w_prod[47]) begin
            w_sig    = w_prod[47:24];
            w_guard  = w_prod[23];
            w_round  = w_prod[22];
            w_sticky = |w_prod[21:0];
            w_exp    = 10'(w_aExp) + 10'(w_bExp) - 10'd126;
         end else begin
            w_sig    = w_prod[46:23];
            w_guard  = w_prod[22];
            w_round  = w_prod[21];
            w_sticky = |w_prod[20:0];
            w_exp    = 10'(w_aExp) + 10'(w_bExp) - 10'd127;
         end
      end else begin
         if (w_quot[26]) begin
            w_sig    = w_quot[26:3];
            w_guard  = w_quot[2];
            w_round  = w_quot[1];
            w_sticky = w_quot[0] | w_divRemNz;
            w_exp    = 10'(w_aExp) - 10'(w_bExp) + 10'd127;
         end else begin
            w_sig    = w_quot[25:2];
            w_guard  = w_quot[1];
            w_round  = w_quot[0];
            w_sticky = w_divRemNz;
            w_exp    = 10'(w_aExp) - 10'(w_bExp) + 10'd126;
         end
      end
   end

   logic               w_roundUp, w_inexact;
   logic [24:0]        w_sigRnd;
   logic signed [9:0]  w_expRnd;
   logic [22:0]        w_fracRnd;

   assign w_roundUp = w_guard && (w_round || w_sticky || w_sig[0]);
   assign w_inexact = w_guard | w_round | w_sticky;
   assign w_sigRnd  = {1'b0, w_sig} + {24'd0, w_roundUp};
   // A carry out of rounding leaves 1.000..0, so only the exponent moves.
   assign w_expRnd  = w_exp + {9'd0, w_sigRnd[24]};
   assign w_fracRnd = w_sigRnd[24] ? w_sigRnd[23:1] : w_sigRnd[22:0];

   logic [31:0] w_res;
   logic        w_io, w_dz, w_of, w_uf, w_ix;

   always_comb begin
      w_res = '0;
      w_io  = 1'b0;
      w_dz  = 1'b0;
      w_of  = 1'b0;
      w_uf  = 1'b0;
      w_ix  = 1'b0;
      if (w_aNan || w_bNan) begin
         w_res = QNAN;
         w_io  = w_aSnan || w_bSnan;
      end else if (!sel ? ((w_aZero && w_bInf) || (w_aInf && w_bZero))
                        : ((w_aZero && w_bZero) || (w_aInf && w_bInf))) begin
         w_res = QNAN;
         w_io  = 1'b1;
      end else if (sel && w_bZero && !w_aZero && !w_aInf) begin
         w_res = {w_sign, 8'hFF, 23'd0};
         w_dz  = 1'b1;
      end else if (!sel ? (w_aInf || w_bInf) : w_aInf) begin
         w_res = {w_sign, 8'hFF, 23'd0};
      end else if (!sel ? (w_aZero || w_bZero) : (w_aZero || w_bInf)) begin
         w_res = {w_sign, 31'd0};
      end else if (w_expRnd >= 10'sd255) begin
         w_res = {w_sign, 8'hFF, 23'd0};
         w_of  = 1'b1;
         w_ix  = 1'b1;
      end else if (w_expRnd <= 10'sd0) begin
         w_res = {w_sign, 31'd0};
         w_uf  = 1'b1;
         w_ix  = 1'b1;
      end else begin
         w_res = {w_sign, w_expRnd[7:0], w_fracRnd};
         w_ix  = w_inexact;
      end
   end

   logic [31:0] r_result;
   logic        r_io, r_dz, r_of, r_uf, r_ix;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_result <= '0;
         r_io     <= 1'b0;
         r_dz     <= 1'b0;
         r_of     <= 1'b0;
         r_uf     <= 1'b0;
         r_ix     <= 1'b0;
      end else if (en) begin
         r_result <= w_res;
         r_io     <= w_io;
         r_dz     <= w_dz;
         r_of     <= w_of;
         r_uf     <= w_uf;
         r_ix     <= w_ix;
      end
   end

   assign R       = r_result;
   assign io_flag = r_io;
   assign dz_flag = r_dz;
   assign of_flag = r_of;
   assign uf_flag = r_uf;
   assign i_flag  = r_ix;

endmodule

// File: tb/tb_fp_mul_div.sv
// Directed vector table, hold/reset sequences and a double-precision based
// reference model for randomized operands of fp_mul_div.
module tb_fp_mul_div;

   logic        clk;
   logic        arst;
   logic [31:0] a, b;
   logic        sel, en;
   logic [31:0] R;
   logic        io_flag, dz_flag, of_flag, uf_flag, i_flag;

   int checkCount = 0;
   int passCount  = 0;

   fp_mul_div dut (
      .clk(clk), .arst(arst), .a(a), .b(b), .sel(sel), .en(en), .R(R),
      .io_flag(io_flag), .dz_flag(dz_flag), .of_flag(of_flag),
      .uf_flag(uf_flag), .i_flag(i_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Flag vector order is {io, dz, of, uf, i}.
   typedef struct {
      string       name;
      logic        sel;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expR;
      logic [4:0]  expF;
   } vec_t;

   vec_t vecs[20];

   task automatic applyStimulus(input logic s, input logic [31:0] opA, input logic [31:0] opB);
      @(negedge clk);
      sel = s;
      a   = opA;
      b   = opB;
      en  = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] expR, input logic [4:0] expF);
      logic [4:0] gotF;
      gotF = {io_flag, dz_flag, of_flag, uf_flag, i_flag};
      checkCount++;
      if (R === expR) passCount++;
      else $display("[TB] FAIL %s result: got %h expected %h", name, R, expR);
      checkCount++;
      if (gotF === expF) passCount++;
      else $display("[TB] FAIL %s flags: got %b expected %b", name, gotF, expF);
   endtask

   // Normal-range reference: exact double product/quotient, rounded to 24 bits here.
   function automatic logic [36:0] refModel(input logic s, input logic [31:0] opA, input logic [31:0] opB);
      real         ra, rb, x, rr;
      logic [63:0] dx;
      logic [23:0] keep;
      logic [28:0] rem;
      logic [24:0] k25;
      logic        up, inex;
      int          fe;
      ra = $bitstoreal({opA[31], 11'(opA[30:23]) + 11'd896, opA[22:0], 29'd0});
      rb = $bitstoreal({opB[31], 11'(opB[30:23]) + 11'd896, opB[22:0], 29'd0});
      x  = s ? ra / rb : ra * rb;
      dx = $realtobits(x);
      keep = {1'b1, dx[51:29]};
      rem  = dx[28:0];
      up   = (rem > 29'h10000000) || ((rem == 29'h10000000) && keep[0]);
      k25  = {1'b0, keep} + {24'd0, up};
      fe   = int'(dx[62:52]) - 896;
      if (k25[24]) begin
         fe  = fe + 1;
         k25 = k25 >> 1;
      end
      if (fe >= 255) return {dx[63], 8'hFF, 23'd0, 5'b00101};
      if (fe <= 0)   return {dx[63], 31'd0, 5'b00011};
      rr   = $bitstoreal({dx[63], 11'(fe + 896), k25[22:0], 29'd0});
      inex = (rem != 29'd0) || (s ? (rr * rb != ra) : (rr != x));
      return {dx[63], 8'(fe), k25[22:0], 4'b0000, inex};
   endfunction

   function automatic logic [31:0] randOperand();
      logic [31:0] v;
      v = $urandom;
      return {v[31], 8'($urandom_range(80, 170)), v[22:0]};
   endfunction

   initial begin
      vecs[0]  = '{"mul1p5x2",    1'b0, 32'h3FC00000, 32'h40000000, 32'h40400000, 5'b00000};
      vecs[1]  = '{"div1by3",     1'b1, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001};
      vecs[2]  = '{"divNegBy0",   1'b1, 32'hBF800000, 32'h00000000, 32'hFF800000, 5'b01000};
      vecs[3]  = '{"mul0xInf",    1'b0, 32'h00000000, 32'h7F800000, 32'h7FC00000, 5'b10000};
      vecs[4]  = '{"mulOverflow", 1'b0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 5'b00101};
      vecs[5]  = '{"mulUnderflow",1'b0, 32'h00800000, 32'h3F000000, 32'h00000000, 5'b00011};
      vecs[6]  = '{"div0by0",     1'b1, 32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000};
      vecs[7]  = '{"divInfByInf", 1'b1, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 5'b10000};
      vecs[8]  = '{"mulQnan",     1'b0, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 5'b00000};
      vecs[9]  = '{"mulSnan",     1'b0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'b10000};
      vecs[10] = '{"mulInfx2",    1'b0, 32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000};
      vecs[11] = '{"divInfBy0",   1'b1, 32'h7F800000, 32'h00000000, 32'h7F800000, 5'b00000};
      vecs[12] = '{"div2ByNegInf",1'b1, 32'h40000000, 32'hFF800000, 32'h80000000, 5'b00000};
      vecs[13] = '{"mulSubnormal",1'b0, 32'h00000001, 32'hC0000000, 32'h80000000, 5'b00000};
      vecs[14] = '{"div0ByNeg1",  1'b1, 32'h00000000, 32'hBF800000, 32'h80000000, 5'b00000};
      vecs[15] = '{"mulSticky",   1'b0, 32'h3F800001, 32'h3F800001, 32'h3F800002, 5'b00001};
      vecs[16] = '{"mulRndCarry", 1'b0, 32'h3F842108, 32'h3FF80000, 32'h40000000, 5'b00001};
      vecs[17] = '{"divQnanBy0",  1'b1, 32'h7FC00000, 32'h00000000, 32'h7FC00000, 5'b00000};
      vecs[18] = '{"div6by2",     1'b1, 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000};
      vecs[19] = '{"mulNeg",      1'b0, 32'hC0400000, 32'h3FC00000, 32'hC0900000, 5'b00000};

      arst = 1'b1;
      en   = 1'b1;
      sel  = 1'b0;
      a    = 32'h3FC00000;
      b    = 32'h40000000;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset", 32'h00000000, 5'b00000);
      @(negedge clk);
      arst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         applyStimulus(vecs[i].sel, vecs[i].a, vecs[i].b);
         checkOutput(vecs[i].name, vecs[i].expR, vecs[i].expF);
      end

      // Outputs must freeze while enable is low, even as operands change.
      applyStimulus(1'b0, 32'h00000000, 32'h7F800000);
      checkOutput("holdStart", 32'h7FC00000, 5'b10000);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         en  = 1'b0;
         sel = 1'b1;
         a   = 32'h3F800000;
         b   = 32'h40400000;
         @(posedge clk);
         #1;
         checkOutput("holdEnLow", 32'h7FC00000, 5'b10000);
      end

      // Random operands with an asynchronous reset pulse landing between edges.
      for (int i = 0; i < 20; i++) begin
         logic [31:0] opA, opB;
         logic        s;
         logic [36:0] exp;
         opA = randOperand();
         opB = randOperand();
         s   = 1'($urandom_range(0, 1));
         exp = refModel(s, opA, opB);
         applyStimulus(s, opA, opB);
         checkOutput(s ? "randDiv" : "randMul", exp[36:5], exp[4:0]);
         if (i == 8) begin
            arst = 1'b1;
            #1;
            checkOutput("asyncReset", 32'h00000000, 5'b00000);
            @(posedge clk);
            #1;
            checkOutput("resetHeld", 32'h00000000, 5'b00000);
            @(negedge clk);
            arst = 1'b0;
         end
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
